// File: rtl/mips_multicycle_core.sv
// ---------------------------------------------------------------------------
// mips_multicycle_core
//   Multi-cycle MIPS32 subset core. A central FSM steps each instruction
//   through FETCH -> DECODE -> EXEC -> {MEM} -> {WB}. One ALU is shared by all
//   states: it computes PC+4 in FETCH, the branch target in DECODE, and the
//   instruction result in EXEC. Instruction and data memories are reached
//   through req/ready handshakes, so either memory may insert wait states.
//
//   Optional feature macro: MIPS_CORE_ILLEGAL_HALT_EN
//     defined   : an unsupported encoding seen in DECODE parks the core in HALT
//                 (halted=1, no requests, no retire) until reset.
//     undefined : unsupported encodings retire as a NOP; halted is tied 0.
//
// Parameters
//   RESET_PC     PC loaded at reset
//   ADDR_W       width of imem_addr / dmem_addr (low bits of byte address)
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   imem_req/addr/rdata/ready    instruction fetch handshake
//   dmem_req/we/addr/wdata/
//   dmem_rdata/ready             data load/store handshake
//   retire_valid, retire_pc      one-cycle pulse + PC of retiring instruction
//   halted                       core stopped on an illegal encoding
// ---------------------------------------------------------------------------
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic              retire_valid,
    output logic [31:0]       retire_pc,
    output logic              halted
);

`ifdef MIPS_CORE_ILLEGAL_HALT_EN
    localparam logic ILLEGAL_HALT = 1'b1;
`else
    localparam logic ILLEGAL_HALT = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] alu_q;
    logic [31:0] mdr_q;
    logic [31:0] retire_pc_q;
    logic [31:0] rf_q [32];

    // ---------------- instruction fields ----------------
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] jtgt;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign jtgt     = ir_q[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // ---------------- decode ----------------
    logic is_r;
    logic is_alu_i;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_j;
    logic legal;

    always_comb begin
        is_r     = (op == OP_RTYPE) &&
                   (funct inside {FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
        is_alu_i = op inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI};
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_bne   = (op == OP_BNE);
        is_j     = (op == OP_J);
        legal    = is_r || is_alu_i || is_lw || is_sw || is_beq || is_bne || is_j;
    end

    // ---------------- shared ALU ----------------
    alu_op_e     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;

    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = a_q;
        alu_b  = b_q;
        case (state_q)
            S_FETCH: begin
                alu_a = pc_q;
                alu_b = 32'd4;
            end
            S_DECODE: begin
                // PC already holds PC+4 here, so this is PC+4+(sext(imm)<<2)
                alu_a = pc_q;
                alu_b = {imm_sext[29:0], 2'b00};
            end
            S_EXEC: begin
                if (is_r) begin
                    case (funct)
                        FN_SUB:  alu_op = ALU_SUB;
                        FN_AND:  alu_op = ALU_AND;
                        FN_OR:   alu_op = ALU_OR;
                        FN_SLT:  alu_op = ALU_SLT;
                        FN_SLL:  alu_op = ALU_SLL;
                        FN_SRL:  alu_op = ALU_SRL;
                        default: alu_op = ALU_ADD;
                    endcase
                    // shifts act on rt by the shamt field
                    if (funct == FN_SLL || funct == FN_SRL) begin
                        alu_a = b_q;
                        alu_b = {27'd0, shamt};
                    end
                end else if (is_beq || is_bne) begin
                    alu_op = ALU_SUB;
                end else begin
                    alu_b = imm_sext;
                    case (op)
                        OP_SLTI: alu_op = ALU_SLT;
                        OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_zext; end
                        OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_zext; end
                        default: alu_op = ALU_ADD;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLL: alu_y = alu_a << alu_b[4:0];
            ALU_SRL: alu_y = alu_a >> alu_b[4:0];
            default: alu_y = alu_a + alu_b;
        endcase
    end

    logic br_taken;
    assign br_taken = is_beq ? (alu_y == 32'd0) : (alu_y != 32'd0);

    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    assign wb_dst  = is_r ? rd : rt;
    assign wb_data = is_lw ? mdr_q : alu_q;

    // ---------------- central FSM ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            retire_pc_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q        <= imem_rdata;
                        retire_pc_q <= pc_q;
                        pc_q        <= alu_y;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= rf_q[rs];
                    b_q   <= rf_q[rt];
                    alu_q <= alu_y;
                    if (legal)             state_q <= S_EXEC;
                    else if (ILLEGAL_HALT) state_q <= S_HALT;
                    else                   state_q <= S_FETCH;
                end
                S_EXEC: begin
                    if (is_beq || is_bne) begin
                        if (br_taken) pc_q <= alu_q;
                        state_q <= S_FETCH;
                    end else if (is_j) begin
                        pc_q    <= {pc_q[31:28], jtgt, 2'b00};
                        state_q <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        alu_q   <= alu_y;
                        state_q <= S_MEM;
                    end else begin
                        alu_q   <= alu_y;
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (is_sw) begin
                            state_q <= S_FETCH;
                        end else begin
                            mdr_q   <= dmem_rdata;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_dst != 5'd0) rf_q[wb_dst] <= wb_data;
                    state_q <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // ---------------- outputs ----------------
    // Reset parks the FSM in FETCH, so the fetch request is masked while
    // reset is held to keep every handshake output low.
    assign imem_req   = reset && (state_q == S_FETCH);
    assign imem_addr  = pc_q[ADDR_W-1:0];
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_req && is_sw;
    assign dmem_addr  = alu_q[ADDR_W-1:0];
    assign dmem_wdata = b_q;
    assign retire_pc  = retire_pc_q;

    assign retire_valid = (state_q == S_WB) ||
                          (state_q == S_EXEC && (is_beq || is_bne || is_j)) ||
                          (state_q == S_MEM && is_sw && dmem_ready) ||
                          (state_q == S_DECODE && !legal && !ILLEGAL_HALT);

`ifdef MIPS_CORE_ILLEGAL_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;
    localparam int DWAIT = 2;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic        halted;

    mips_multicycle_core #(.RESET_PC(32'h100), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory models ----------------
    logic [31:0] imem [256];
    logic [31:0] dmem [64];
    int          dcnt;

    assign imem_ready = 1'b1;
    assign imem_rdata = imem[imem_addr[9:2]];
    assign dmem_rdata = dmem[dmem_addr[7:2]];
    assign dmem_ready = dmem_req && (dcnt >= DWAIT);

    always @(posedge clock) begin
        if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
        else                         dcnt <= 0;
        if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] ej(input logic [31:0] addr);
        return {6'h02, addr[27:2]};
    endfunction
    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        imem[addr[9:2]] = word;
    endtask

    // ---------------- event logs ----------------
    int          cyc = 0;
    int          ret_cyc[$];
    logic [31:0] ret_pc[$];
    logic [31:0] fetch_q[$];
    logic [31:0] st_a[$];
    logic [31:0] st_d[$];
    logic        pw = 1'b0;
    logic        pwe;
    logic [31:0] pa;
    logic [31:0] pd;

    // Cycle 1 is the first clock period after reset deasserts; samples are
    // taken mid-cycle on the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            cyc <= cyc + 1;
            if (retire_valid) begin
                ret_cyc.push_back(cyc + 1);
                ret_pc.push_back(retire_pc);
            end
            if (imem_req && imem_ready) fetch_q.push_back(imem_addr);
            if (dmem_req && dmem_ready && dmem_we) begin
                st_a.push_back(dmem_addr);
                st_d.push_back(dmem_wdata);
            end
            if (pw) begin
                chk("dmem_hold_req", {31'd0, dmem_req}, 32'd1);
                chk("dmem_hold_we", {31'd0, dmem_we}, {31'd0, pwe});
                chk("dmem_hold_addr", dmem_addr, pa);
                chk("dmem_hold_wdata", dmem_wdata, pd);
            end
            pw  <= dmem_req && !dmem_ready;
            pwe <= dmem_we;
            pa  <= dmem_addr;
            pd  <= dmem_wdata;
        end
    end

    // ---------------- expected tables ----------------
    logic [31:0] exp_pc [32];
    logic [31:0] exp_sa [11];
    logic [31:0] exp_sd [11];

`ifdef MIPS_CORE_ILLEGAL_HALT_EN
    localparam int EXP_RET = 31;
`else
    localparam int EXP_RET = 32;
`endif

    initial begin
        reset = 1'b0;
        dcnt  = 0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        for (int i = 0; i < 64; i++)  dmem[i] = 32'h0;

        put(32'h100, ei(6'h08, 0, 1, 16'd5));        // addi $1,$0,5
        put(32'h104, ei(6'h08, 0, 2, 16'hFFFD));     // addi $2,$0,-3
        put(32'h108, er(1, 2, 3, 0, 6'h20));         // add  $3,$1,$2
        put(32'h10C, er(2, 1, 4, 0, 6'h2A));         // slt  $4,$2,$1
        put(32'h110, ei(6'h2B, 0, 3, 16'd8));        // sw   $3,8($0)
        put(32'h114, ei(6'h23, 0, 5, 16'd8));        // lw   $5,8($0)
        put(32'h118, ei(6'h2B, 0, 4, 16'd12));       // sw   $4,12($0)
        put(32'h11C, ei(6'h2B, 0, 5, 16'd16));       // sw   $5,16($0)
        put(32'h120, ei(6'h08, 0, 0, 16'd7));        // addi $0,$0,7
        put(32'h124, er(0, 0, 6, 0, 6'h20));         // add  $6,$0,$0
        put(32'h128, ei(6'h2B, 0, 6, 16'd20));       // sw   $6,20($0)
        put(32'h12C, ei(6'h0D, 0, 7, 16'h8001));     // ori  $7,$0,0x8001
        put(32'h130, ei(6'h2B, 0, 7, 16'd24));       // sw   $7,24($0)
        put(32'h134, ej(32'h20));                    // j    0x20
        put(32'h01C, ei(6'h08, 0, 8, 16'd1));        // addi $8,$0,1
        put(32'h020, ei(6'h04, 8, 0, 16'hFFFE));     // beq  $8,$0,-2
        put(32'h024, ei(6'h05, 1, 1, 16'd10));       // bne  $1,$1,10 (not taken)
        put(32'h028, ei(6'h05, 1, 2, 16'd2));        // bne  $1,$2,2 -> 0x34
        put(32'h034, er(0, 1, 9, 4, 6'h00));         // sll  $9,$1,4
        put(32'h038, er(0, 2, 10, 28, 6'h02));       // srl  $10,$2,28
        put(32'h03C, er(1, 2, 11, 0, 6'h22));        // sub  $11,$1,$2
        put(32'h040, ei(6'h0A, 2, 12, 16'd0));       // slti $12,$2,0
        put(32'h044, er(1, 2, 13, 0, 6'h24));        // and  $13,$1,$2
        put(32'h048, er(1, 2, 14, 0, 6'h25));        // or   $14,$1,$2
        for (int i = 0; i < 6; i++)                  // sw $9..$14 -> 28..48
            put(32'h04C + 32'(4 * i), ei(6'h2B, 0, 5'(9 + i), 16'(28 + 4 * i)));
        put(32'h064, 32'hFC00_0000);                 // opcode 0x3F
        put(32'h068, ej(32'h68));                    // j self

        for (int i = 0; i < 14; i++) exp_pc[i] = 32'h100 + 32'(4 * i);
        exp_pc[14] = 32'h20; exp_pc[15] = 32'h1C; exp_pc[16] = 32'h20;
        exp_pc[17] = 32'h24; exp_pc[18] = 32'h28;
        for (int i = 0; i < 12; i++) exp_pc[19 + i] = 32'h34 + 32'(4 * i);
        exp_pc[31] = 32'h64;

        exp_sa = '{32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36, 32'd40, 32'd44, 32'd48};
        exp_sd = '{32'd2, 32'd1, 32'd2, 32'd0, 32'h8001, 32'h50, 32'hF, 32'd8, 32'd1, 32'd5, 32'hFFFF_FFFD};

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h100);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_retire_valid", {31'd0, retire_valid}, 32'd0);
        chk("rst_retire_pc", retire_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("c1_imem_req", {31'd0, imem_req}, 32'd1);
        chk("c1_imem_addr", imem_addr, 32'h100);

        for (int i = 0; i < 3000; i++) begin
            if (fetch_q.size() >= 33 || halted) break;
            @(posedge clock);
        end
        repeat (20) @(posedge clock);
        @(negedge clock);

        // retire sequence, one fetch per retired instruction
        for (int i = 0; i < EXP_RET; i++) begin
            chk($sformatf("ret_pc[%0d]", i), (i < ret_pc.size()) ? ret_pc[i] : 32'hDEAD_DEAD, exp_pc[i]);
            chk($sformatf("fetch[%0d]", i), (i < fetch_q.size()) ? fetch_q[i] : 32'hDEAD_DEAD, exp_pc[i]);
        end

        // cycle timing
        if (ret_cyc.size() >= 19) begin
            chk("cyc_ret0", ret_cyc[0], 4);
            chk("cyc_ret1", ret_cyc[1], 8);
            chk("cyc_ret2", ret_cyc[2], 12);
            chk("cyc_ret3", ret_cyc[3], 16);
            chk("cyc_sw_wait", ret_cyc[4] - ret_cyc[3], 6);
            chk("cyc_lw_wait", ret_cyc[5] - ret_cyc[4], 7);
            chk("cyc_j", ret_cyc[13] - ret_cyc[12], 3);
            chk("cyc_beq_taken", ret_cyc[14] - ret_cyc[13], 3);
            chk("cyc_beq_not", ret_cyc[16] - ret_cyc[15], 3);
            chk("cyc_bne_not", ret_cyc[17] - ret_cyc[16], 3);
            chk("cyc_bne_taken", ret_cyc[18] - ret_cyc[17], 3);
        end else begin
            chk("retire_count_min", ret_cyc.size(), 19);
        end

        // stores expose register values
        chk("store_count", st_a.size(), 11);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("st_addr[%0d]", i), (i < st_a.size()) ? st_a[i] : 32'hDEAD_DEAD, exp_sa[i]);
            chk($sformatf("st_data[%0d]", i), (i < st_d.size()) ? st_d[i] : 32'hDEAD_DEAD, exp_sd[i]);
        end

`ifdef MIPS_CORE_ILLEGAL_HALT_EN
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
        chk("halt_fetches", fetch_q.size(), 32);
        chk("halt_retires", ret_pc.size(), 31);
`else
        chk("halted", {31'd0, halted}, 32'd0);
        chk("fetch_after_illegal", (fetch_q.size() > 32) ? fetch_q[32] : 32'hDEAD_DEAD, 32'h68);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
